// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA scan-out path.
//   LINE_W / ROWS       : visible line geometry (pixels, rows)
//   H_TOTAL / V_TOTAL   : full raster timing including blanking
//   fetch_state_t       : line-fetch FSM state encoding
//   row_next()          : next row to prefetch, wrapping the last row to 0
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int LINE_W  = 640;
    localparam int ROWS    = 480;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 521;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // Row following `row`; the last visible row wraps to row 0 of the next frame.
    function automatic logic [8:0] row_next(input logic [8:0] row);
        logic [8:0] nxt_s;
        if (row == 9'(ROWS - 1)) begin
            nxt_s = 9'd0;
        end else begin
            nxt_s = row + 9'd1;
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/vram_word_reader.sv
// -----------------------------------------------------------------------------
// vram_word_reader
// Walks one row of video RAM word by word over a single-outstanding read
// handshake and hands each returned word to the line buffer.
//   dclk, rst_n          : pixel clock, async active-low reset
//   start, start_row     : begin (or restart) fetching row start_row
//   mem_rd_en/mem_addr   : one-cycle read request (only ever driven in REQ)
//   mem_rdata/mem_rvalid : read response, one per request
//   wr_en/wr_idx/wr_data : word-write strobe into the back buffer
//   wr_last/wr_row       : this write completes row wr_row
//   busy (LINE_FETCH_STATS_EN only) : FSM is not idle
// A restart while a response is still owed goes through DRAIN so the stale
// word is swallowed and never reaches the back buffer.
// -----------------------------------------------------------------------------
module vram_word_reader
    import vga_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int WORDS  = 20,
    parameter int ADDR_W = 14,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [8:0]        start_row,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              wr_en,
    output logic              wr_last,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [WORD_W-1:0] wr_data,
    output logic [8:0]        wr_row
`ifdef LINE_FETCH_STATS_EN
    ,
    output logic              busy
`endif
);

    fetch_state_t      state_r, state_n_s;
    logic [IDX_W-1:0]  k_r, k_n_s;
    logic [8:0]        tgt_r, tgt_n_s;
    logic              rd_en_r;
    logic [ADDR_W-1:0] addr_r, addr_n_s;
    logic              last_s, wr_en_s;
`ifdef LINE_FETCH_STATS_EN
    logic              busy_r;
`endif

    assign last_s = (k_r == IDX_W'(WORDS - 1));

    // Next-state logic for the request/response handshake.
    always_comb begin
        state_n_s = state_r;
        k_n_s     = k_r;
        tgt_n_s   = tgt_r;
        wr_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n_s = REQ;
                    k_n_s     = '0;
                    tgt_n_s   = start_row;
                end else begin
                    state_n_s = IDLE;
                end
            end
            REQ: begin
                // The request on the bus this cycle is taken by memory at this
                // edge regardless, so a restart must still drain its response.
                if (start) begin
                    state_n_s = DRAIN;
                    k_n_s     = '0;
                    tgt_n_s   = start_row;
                end else begin
                    state_n_s = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (start) begin
                        // Only a row-completing word is kept on a restart edge.
                        wr_en_s   = last_s;
                        state_n_s = REQ;
                        k_n_s     = '0;
                        tgt_n_s   = start_row;
                    end else begin
                        wr_en_s = 1'b1;
                        if (last_s) begin
                            state_n_s = IDLE;
                        end else begin
                            state_n_s = REQ;
                            k_n_s     = k_r + IDX_W'(1);
                        end
                    end
                end else if (start) begin
                    state_n_s = DRAIN;
                    k_n_s     = '0;
                    tgt_n_s   = start_row;
                end else begin
                    state_n_s = WAIT;
                end
            end
            DRAIN: begin
                if (start) begin
                    tgt_n_s = start_row;
                end else begin
                    tgt_n_s = tgt_r;
                end
                if (mem_rvalid) begin
                    state_n_s = REQ;
                end else begin
                    state_n_s = DRAIN;
                end
            end
            default: begin
                state_n_s = IDLE;
                k_n_s     = '0;
            end
        endcase
    end

    assign addr_n_s = ADDR_W'(tgt_n_s) * ADDR_W'(WORDS) + ADDR_W'(k_n_s);

    // State, word index, target row and the registered request outputs.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            k_r     <= '0;
            tgt_r   <= 9'd0;
            rd_en_r <= 1'b0;
            addr_r  <= '0;
        end else begin
            state_r <= state_n_s;
            k_r     <= k_n_s;
            tgt_r   <= tgt_n_s;
            rd_en_r <= (state_n_s == REQ);
            if (state_n_s == REQ) begin
                addr_r <= addr_n_s;
            end
        end
    end

`ifdef LINE_FETCH_STATS_EN
    // Registered busy flag, mirrors "state is not IDLE".
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_n_s != IDLE);
        end
    end
    assign busy = busy_r;
`endif

    assign mem_rd_en = rd_en_r;
    assign mem_addr  = addr_r;
    assign wr_en     = wr_en_s;
    assign wr_last   = wr_en_s & last_s;
    assign wr_idx    = k_r;
    assign wr_data   = mem_rdata;
    assign wr_row    = tgt_r;

endmodule

// File: rtl/vram_line_fetch.sv
// -----------------------------------------------------------------------------
// vram_line_fetch
// Feeds the VGA scan-out stage: presents the requested row as a LINE_W-bit
// vector one cycle after row_addr changes, while prefetching the next row from
// video RAM into a back buffer.
//   dclk, rst_n           : pixel clock, async active-low reset
//   row_addr              : row requested by scan-out (level)
//   line                  : front buffer, bit p = pixel p
//   mem_rd_en, mem_addr   : read request to video RAM
//   mem_rdata, mem_rvalid : read response
//   underrun              : sticky, a swap found no ready prefetch
// Optional (macro LINE_FETCH_STATS_EN):
//   underrun_cnt          : saturating count of underrun events
//   fetch_busy            : fetch FSM is not idle
// -----------------------------------------------------------------------------
module vram_line_fetch #(
    parameter int LINE_W = vga_pkg::LINE_W,
    parameter int WORD_W = 32,
    parameter int ROWS   = vga_pkg::ROWS,
    parameter int ADDR_W = 14
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic [8:0]        row_addr,
    output logic [LINE_W-1:0] line,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              underrun
`ifdef LINE_FETCH_STATS_EN
    ,
    output logic [15:0]       underrun_cnt,
    output logic              fetch_busy
`endif
);

    import vga_pkg::*;

    localparam int WORDS = LINE_W / WORD_W;
    localparam int IDX_W = $clog2(WORDS);

    logic [8:0]        row_q_r;
    logic [LINE_W-1:0] line_r, line_n_s;
    logic              underrun_r;
    logic [LINE_W-1:0] back_r, back_next_s;
    logic              back_valid_r, back_valid_n_s;
    logic [8:0]        back_row_r, back_row_n_s;

    logic              row_change_s, in_range_s, eff_valid_s, underrun_evt_s;
    logic [8:0]        eff_row_s;
    logic              start_s;
    logic [8:0]        start_row_s;

    logic              wr_en_s, wr_last_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [WORD_W-1:0] wr_data_s;
    logic [8:0]        wr_row_s;

    vram_word_reader #(
        .WORD_W (WORD_W),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_reader (
        .dclk       (dclk),
        .rst_n      (rst_n),
        .start      (start_s),
        .start_row  (start_row_s),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .wr_en      (wr_en_s),
        .wr_last    (wr_last_s),
        .wr_idx     (wr_idx_s),
        .wr_data    (wr_data_s),
        .wr_row     (wr_row_s)
`ifdef LINE_FETCH_STATS_EN
        ,
        .busy       (fetch_busy)
`endif
    );

    assign row_change_s = (row_addr != row_q_r);
    assign in_range_s   = (row_addr < 9'(ROWS));

    // Swap decision and prefetch launch. A word completing the back buffer on
    // this very edge is folded in first, so a just-finished row still swaps.
    always_comb begin
        back_next_s = back_r;
        if (wr_en_s) begin
            back_next_s[wr_idx_s*WORD_W +: WORD_W] = wr_data_s;
        end else begin
            back_next_s = back_r;
        end
        eff_valid_s    = back_valid_r | wr_last_s;
        eff_row_s      = wr_last_s ? wr_row_s : back_row_r;
        start_s        = 1'b0;
        start_row_s    = 9'd0;
        underrun_evt_s = 1'b0;
        line_n_s       = line_r;
        if (row_change_s) begin
            if (in_range_s) begin
                start_s     = 1'b1;
                start_row_s = row_next(row_addr);
                if (eff_valid_s && (eff_row_s == row_addr)) begin
                    line_n_s = back_next_s;
                end else begin
                    line_n_s       = '0;
                    underrun_evt_s = 1'b1;
                end
            end else begin
                // Vertical blank: blank the line and make sure row 0 is ready.
                line_n_s    = '0;
                start_row_s = 9'd0;
                if (eff_valid_s && (eff_row_s == 9'd0)) begin
                    start_s = 1'b0;
                end else begin
                    start_s = 1'b1;
                end
            end
        end else begin
            line_n_s = line_r;
        end
        if (start_s) begin
            back_valid_n_s = 1'b0;
        end else if (wr_last_s) begin
            back_valid_n_s = 1'b1;
        end else begin
            back_valid_n_s = back_valid_r;
        end
        back_row_n_s = wr_last_s ? wr_row_s : back_row_r;
    end

    // Row tracking, front/back buffers and the sticky underrun flag.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            row_q_r      <= 9'h1FF;
            line_r       <= '0;
            underrun_r   <= 1'b0;
            back_r       <= '0;
            back_valid_r <= 1'b0;
            back_row_r   <= 9'd0;
        end else begin
            row_q_r      <= row_addr;
            line_r       <= line_n_s;
            if (underrun_evt_s) begin
                underrun_r <= 1'b1;
            end
            back_r       <= back_next_s;
            back_valid_r <= back_valid_n_s;
            back_row_r   <= back_row_n_s;
        end
    end

`ifdef LINE_FETCH_STATS_EN
    logic [15:0] underrun_cnt_r;

    // Saturating underrun event counter.
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_r <= 16'd0;
        end else if (underrun_evt_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'd1;
        end
    end
    assign underrun_cnt = underrun_cnt_r;
`endif

    assign line     = line_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_vram_line_fetch.sv
// -----------------------------------------------------------------------------
// tb_vram_line_fetch
// Directed bench for vram_line_fetch. The memory model returns data equal to
// the word address after a programmable latency and records every request.
// -----------------------------------------------------------------------------
module tb_vram_line_fetch;

    localparam int LW = 640;
    localparam int WW = 32;
    localparam int NW = 20;
    localparam int AW = 14;

    logic          dclk  = 1'b0;
    logic          rst_n = 1'b1;
    logic [8:0]    row_addr;
    logic [LW-1:0] line;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic          underrun;
`ifdef LINE_FETCH_STATS_EN
    logic [15:0]   underrun_cnt;
    logic          fetch_busy;
`endif

    int n_checks  = 0;
    int n_fail    = 0;
    int lat       = 3;
    int resp_cnt  = 0;
    int nreq      = 0;
    int proto_err = 0;
    int req_q[$];
    int snap_q[$];

    always #20 dclk = ~dclk;

    vram_line_fetch dut (
        .dclk       (dclk),
        .rst_n      (rst_n),
        .row_addr   (row_addr),
        .line       (line),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .underrun   (underrun)
`ifdef LINE_FETCH_STATS_EN
        ,
        .underrun_cnt (underrun_cnt),
        .fetch_busy   (fetch_busy)
`endif
    );

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge dclk);
    endtask

    // Expected line for row r when memory returns data = word address.
    function automatic logic [LW-1:0] row_vec(input int r);
        logic [LW-1:0] v;
        v = '0;
        for (int k = 0; k < NW; k++) begin
            v[k*WW +: WW] = WW'(r * NW + k);
        end
        return v;
    endfunction

    // Memory model: request seen at an edge is answered `lat` edges later.
    initial begin : mem_model
        logic          req_v;
        logic [AW-1:0] req_a;
        logic [AW-1:0] pa;
        bit            pend;
        int            cnt;
        pend = 1'b0;
        cnt  = 0;
        pa   = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge dclk);
            req_v = mem_rd_en;
            req_a = mem_addr;
            @(posedge dclk);
            if (pend && cnt > 0) cnt--;
            if (req_v) begin
                if (pend) proto_err++;
                pend = 1'b1;
                cnt  = lat - 1;
                pa   = req_a;
                nreq++;
                req_q.push_back(int'(req_a));
                snap_q.push_back(resp_cnt);
            end
            #1;
            if (pend && cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = WW'(pa);
                pend       = 1'b0;
                resp_cnt++;
            end else begin
                mem_rvalid = 1'b0;
            end
        end
    end

    initial begin : stim
        int  first;
        int  base;
        bit  ok;
        row_addr = 9'h1FF;
        #1 rst_n = 1'b0;
        #4;
        check_eq("rst_line", line, '0);
        check_eq("rst_rd_en", mem_rd_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_underrun", underrun, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        check_eq("idle_no_req", nreq, 0);

        // Step rows 5 then 6.
        row_addr = 9'd5;
        cyc(1);
        check_eq("row5_line", line, '0);
        check_eq("row5_underrun", underrun, 1);
        check_eq("row5_rd_en", mem_rd_en, 1);
        check_eq("row5_prefetch_addr", mem_addr, 120);
        cyc(99);
        row_addr = 9'd6;
        cyc(1);
        check_eq("row6_line", line, row_vec(6));
        check_eq("row6_underrun", underrun, 1);

        // Wrap at the last row.
        row_addr = 9'd478;
        cyc(100);
        req_q.delete();
        row_addr = 9'd479;
        cyc(1);
        check_eq("row479_line", line, row_vec(479));
        cyc(99);
        check_eq("wrap_req_count", req_q.size(), 20);
        ok = 1'b1;
        for (int i = 0; i < req_q.size(); i++) begin
            if (req_q[i] != i) ok = 1'b0;
        end
        check_eq("wrap_req_addrs", ok, 1);
        row_addr = 9'd480;
        cyc(1);
        check_eq("vblank_line", line, '0);
        check_eq("vblank_underrun", underrun, 1);
        cyc(5);
        check_eq("vblank_no_refetch", req_q.size(), 20);
        row_addr = 9'd0;
        cyc(1);
        check_eq("row0_line", line, row_vec(0));
`ifdef LINE_FETCH_STATS_EN
        check_eq("wrap_underrun_cnt", underrun_cnt, 2);
`endif

        // Same-edge completion, starting from a clean reset via vertical blank.
        rst_n    = 1'b0;
        row_addr = 9'h1FF;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        check_eq("rst2_underrun", underrun, 0);
        nreq     = 0;
        row_addr = 9'd500;
        cyc(80);
        check_eq("same_edge_reqs", nreq, 20);
        lat      = 32;
        row_addr = 9'd0;
        cyc(1);
        check_eq("same_edge_line", line, row_vec(0));
        check_eq("same_edge_underrun", underrun, 0);

        // Abort during WAIT (latency 32).
        cyc(9);
        req_q.delete();
        snap_q.delete();
        base     = resp_cnt;
        row_addr = 9'd10;
        cyc(60);
        first = (req_q.size() > 0) ? req_q[0] : -1;
        check_eq("abort_next_addr", first, 220);
        first = (snap_q.size() > 0) ? (snap_q[0] - base) : -1;
        check_eq("abort_one_discard", first, 1);
        check_eq("abort_underrun", underrun, 1);
        cyc(700);
        row_addr = 9'd11;
        cyc(1);
        check_eq("abort_row11_line", line, row_vec(11));

        // Reset while a fetch is waiting on memory.
        cyc(10);
        rst_n    = 1'b0;
        row_addr = 9'h1FF;
        #2;
        check_eq("midrst_line", line, '0);
        check_eq("midrst_rd_en", mem_rd_en, 0);
        check_eq("midrst_addr", mem_addr, 0);
        check_eq("midrst_underrun", underrun, 0);
`ifdef LINE_FETCH_STATS_EN
        check_eq("midrst_cnt", underrun_cnt, 0);
        check_eq("midrst_busy", fetch_busy, 0);
`endif
        cyc(2);
        rst_n = 1'b1;
        req_q.delete();
        cyc(40);
        check_eq("late_rvalid_no_req", req_q.size(), 0);
        check_eq("late_rvalid_line", line, '0);

        // Forced underruns and fetch activity.
        lat      = 1;
        row_addr = 9'd20;
        cyc(3);
        first = (req_q.size() > 0) ? req_q[0] : -1;
        check_eq("post_rst_first_addr", first, 420);
        check_eq("post_rst_underrun", underrun, 1);
`ifdef LINE_FETCH_STATS_EN
        check_eq("busy_during_fetch", fetch_busy, 1);
`endif
        cyc(50);
`ifdef LINE_FETCH_STATS_EN
        check_eq("busy_after_fetch", fetch_busy, 0);
`endif
        row_addr = 9'd100;
        cyc(2);
        row_addr = 9'd200;
        cyc(2);
`ifdef LINE_FETCH_STATS_EN
        check_eq("underrun_cnt3", underrun_cnt, 3);
`endif
        check_eq("final_underrun", underrun, 1);
        cyc(50);
        check_eq("single_outstanding", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
